// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - two-master round-robin arbiter for the shared memory/IO bus
// One transaction at a time; a watchdog ends stalled accesses with a bus error.
`timescale 1ns/1ps
module mio_bus_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  input  logic          dev_rd,
  input  logic          dev_wr,
  input  logic [AW-1:0] dev_addr,
  input  logic [31:0]   dev_wdata,
  output logic [31:0]   dev_rdata,
  output logic          dev_ready,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic [1:0]    grant,
  output logic          bus_err,
  output logic [1:0]    state_out
);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ACCESS = 2'b01;
  localparam logic [1:0] S_DONE   = 2'b10;
  localparam logic [7:0] TLIM     = 8'(TIMEOUT - 1);

  logic [1:0]    state;
  logic          last_dev;
  logic [7:0]    cnt;

  logic          cpu_pend;
  logic          dev_pend;
  logic          pick_dev;
  logic          sel_rd;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;

  assign state_out = state;

  // On a tie the master that did not own the bus last time wins.
  always_comb begin
    cpu_pend  = cpu_rd | cpu_wr;
    dev_pend  = dev_rd | dev_wr;
    pick_dev  = dev_pend & (~cpu_pend | ~last_dev);
    sel_rd    = pick_dev ? dev_rd    : cpu_rd;
    sel_wr    = pick_dev ? dev_wr    : cpu_wr;
    sel_addr  = pick_dev ? dev_addr  : cpu_addr;
    sel_wdata = pick_dev ? dev_wdata : cpu_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      grant     <= 2'b00;
      last_dev  <= 1'b1;
      cnt       <= 8'd0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      cpu_rdata <= 32'h0;
      dev_rdata <= 32'h0;
      cpu_ready <= 1'b0;
      dev_ready <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cpu_ready <= 1'b0;
          dev_ready <= 1'b0;
          bus_err   <= 1'b0;
          if (cpu_pend | dev_pend) begin
            state     <= S_ACCESS;
            grant     <= pick_dev ? 2'b10 : 2'b01;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wr    <= sel_wr;
            mem_rd    <= sel_rd & ~sel_wr;
            cnt       <= 8'd0;
          end
        end

        S_ACCESS: begin
          cnt <= cnt + 8'd1;
          // Ack wins over the watchdog when both land in the same cycle.
          if (mem_ack || cnt == TLIM) begin
            if (mem_rd) begin
              if (grant[1]) dev_rdata <= mem_ack ? mem_rdata : 32'h0;
              else          cpu_rdata <= mem_ack ? mem_rdata : 32'h0;
            end
            bus_err   <= ~mem_ack;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            cpu_ready <= grant[0];
            dev_ready <= grant[1];
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          cpu_ready <= 1'b0;
          dev_ready <= 1'b0;
          bus_err   <= 1'b0;
          last_dev  <= grant[1];
          grant     <= 2'b00;
          state     <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          grant     <= 2'b00;
          mem_rd    <= 1'b0;
          mem_wr    <= 1'b0;
          cpu_ready <= 1'b0;
          dev_ready <= 1'b0;
          bus_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Arbitrates the single shared memory/IO bus between two masters: the multi-cycle CPU controller (port CPU) and the polling IO/peripheral engine (port DEV).
- Generates each master's ready pulse; CPU's `cpu_ready` drives the controller's MIO_ready.
- Round-robin on contention, one transaction at a time.
- A watchdog terminates stalled accesses with a bus error.

Parameters:
- AW, 32, address width of all address ports.
- TIMEOUT, 16, max ACCESS cycles waiting for mem_ack before error; legal range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- cpu_rd  in  1  CPU read request (level, held until cpu_ready)
- cpu_wr  in  1  CPU write request (level, held until cpu_ready)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  32  CPU write data
- cpu_rdata  out  32  CPU read data, valid in cpu_ready cycle, held until next CPU completion
- cpu_ready  out  1  one-cycle completion pulse to CPU
- dev_rd, dev_wr, dev_addr, dev_wdata  in  1,1,AW,32  DEV request, same rules as CPU
- dev_rdata  out  32  DEV read data, same rules as cpu_rdata
- dev_ready  out  1  one-cycle completion pulse to DEV
- mem_rd  out  1  bus read strobe
- mem_wr  out  1  bus write strobe
- mem_addr  out  AW  bus address
- mem_wdata  out  32  bus write data
- mem_rdata  in  32  bus read data, sampled on mem_ack
- mem_ack  in  1  bus completion, single cycle
- grant  out  2  01 CPU owns bus, 10 DEV owns bus, 00 none
- bus_err  out  1  one-cycle pulse coincident with ready when transaction timed out
- state_out  out  2  current FSM state encoding

Behaviour:
- All outputs registered.
- Reset (reset_n low, async):
  - state IDLE (00); grant 00.
  - mem_rd/mem_wr/cpu_ready/dev_ready/bus_err all 0.
  - mem_addr, mem_wdata, cpu_rdata, dev_rdata all 0.
  - last_grant = DEV, so CPU wins the first tie.
  - Watchdog counter 0.
  - Reset mid-transaction aborts it silently: no ready pulse.
- A request is pending when rd|wr is set. If both are set, it is treated as a write (mem_wr only).
- States: IDLE=00, ACCESS=01, DONE=10, 11 unused (recovers to IDLE).
- IDLE:
  - If only one master is pending, grant it.
  - If both are pending, grant the master that is not last_grant.
  - On grant: latch addr/wdata onto mem_addr/mem_wdata, assert mem_rd or mem_wr, set grant, clear counter → ACCESS.
  - If neither is pending, stay in IDLE.
- ACCESS:
  - Strobes and bus outputs are held constant. Counter increments each cycle.
  - If mem_ack: on a read, capture mem_rdata into the granted master's rdata register (write leaves rdata unchanged); drop strobes → DONE.
  - Else if counter == TIMEOUT-1: drop strobes, set err flag, load rdata with 32'h0 on a read → DONE.
  - If ack arrives on the timeout cycle, ack wins and no error is flagged.
- DONE (exactly one cycle):
  - Granted master's ready = 1; bus_err = err flag.
  - last_grant updated to this master; grant → 00 → IDLE.
- Ready and bus_err are forced 0 in every other cycle.
- mem_ack outside ACCESS is ignored.
- Masters must deassert rd/wr in the cycle after their ready. A request seen in IDLE is always a new transaction.
- Minimum latency: request seen in IDLE at cycle 0 → ACCESS at cycle 1 → ack at cycle 1 → ready in cycle 2. Each extra ack wait adds one cycle.
- No back-to-back grants without an IDLE cycle, so the bus is idle at least 1 cycle between transactions.
- The losing master's request stays pending unchanged; it is served at the next IDLE. Fairness bound: one intervening transaction.

Test Plan:
- Reset then CPU read of addr 0x0000_0010, mem_ack one cycle after strobe with mem_rdata 0x1234_5678 → mem_rd high 2 cycles, grant 01; cpu_ready pulse with cpu_rdata 0x1234_5678; dev_ready stays 0.
- CPU and DEV both write in the same IDLE cycle after reset → CPU served first. DEV is granted in the IDLE following CPU's DONE, and mem_addr/mem_wdata then show DEV's values.
- Continuous CPU and DEV read requests for 6 transactions → grants alternate CPU, DEV, CPU, DEV, CPU, DEV.
- DEV read, mem_ack never asserted, TIMEOUT=16 → mem_rd high exactly 16 cycles, then dev_ready and bus_err pulse together with dev_rdata 0x0000_0000.
- mem_ack exactly on cycle TIMEOUT-1 → ready pulses, bus_err 0, data captured.
- reset_n low while in ACCESS → strobes, grant, and ready drop immediately. After release, state_out is 00 and no ready is issued for the aborted request.
- CPU with cpu_rd and cpu_wr both set, wdata 0xA5A5_A5A5 → only mem_wr asserted; cpu_rdata unchanged.
